unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Sequences a single-port backing memory shared by the pipeline's instruction-fetch (IF) and data-access (MEM) stages. Each granted access is held for a fixed `MEM_LATENCY` cycles, then completed with a one-cycle ready pulse. Contention is resolved by round-robin. Sits between the IF/MEM stages and the unified memory array; while a requester's `*_ready` is low, the hazard logic stalls the pipeline.

## Interface
- `WORD_W`, 32, data width
- `ADDR_W`, 32, byte-address width
- `MEM_LATENCY`, 4, cycles per access (>= 1)
- `clk`  in  1  clock; everything on rising edge
- `reset`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held until `if_ready`
- `if_addr`  in  ADDR_W  fetch address
- `if_ready`  out  1  one-cycle completion pulse for fetch
- `if_rdata`  out  WORD_W  fetched word; valid only while `if_ready`
- `d_req`  in  1  data request; held until `d_ready`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  WORD_W  store data
- `d_ready`  out  1  one-cycle completion pulse for data
- `d_rdata`  out  WORD_W  load data; valid only while `d_ready`
- `m_addr`  out  ADDR_W  memory address (latched at grant)
- `m_wdata`  out  WORD_W  memory write data (latched at grant)
- `m_we`  out  1  memory write strobe; memory writes at the rising edge ending the cycle
- `m_rdata`  in  WORD_W  asynchronous memory read data for `m_addr`

## Operation
- States: IDLE, BUSY_I, BUSY_D. One 1-bit `last_grant` register (0 = IF, 1 = data).
- **IDLE → grant:**
  - Only `if_req` high → BUSY_I.
  - Only `d_req` high → BUSY_D.
  - Both high → grant the side opposite `last_grant`.
- **At grant:**
  - Latch `m_addr` from the granted address.
  - For data stores, also latch `m_wdata` and a pending-write flag. Fetches never write.
  - Load the counter with `MEM_LATENCY-1`.
  - Update `last_grant`.
- **BUSY_x:**
  - While counter > 0: decrement; `m_addr` and `m_wdata` are held.
  - When counter == 0 (done cycle):
    - Assert the granted side's `*_ready`.
    - Drive its `*_rdata` = `m_rdata`.
    - Assert `m_we` only for a store.
    - Return to IDLE at the end of the cycle.
- `*_rdata` = 0 whenever the matching `*_ready` is low.
- Request inputs are sampled only in IDLE. Address or data changes after grant are ignored.
- A request dropped mid-transaction still completes: the ready pulse is issued and a store is still written. The requester ignores the pulse.
- IDLE with no requests: all outputs at their reset values, except `m_addr`/`m_wdata`, which hold their last latched values.
- `MEM_LATENCY` = 1: grant cycle +1 is the done cycle (counter loads 0).

## Timing
- Request high in IDLE at cycle t → granted state from t+1 → `*_ready` pulse at cycle t+`MEM_LATENCY`.
- IDLE cycle between transactions is mandatory. Back-to-back throughput is 1 access per `MEM_LATENCY`+1 cycles.
- Under continuous contention, grants strictly alternate IF/data. Neither side waits more than one foreign transaction.
- Store commits at the rising edge ending the `d_ready` cycle. A load issued next sees the new value.
- **Reset:**
  - State = IDLE, counter = 0, `last_grant` = 1 (IF wins the first tie).
  - `m_addr` = 0, `m_wdata` = 0, pending-write = 0.
  - `m_we`, `if_ready`, `d_ready` = 0; `if_rdata`, `d_rdata` = 0.
- Reset mid-transaction aborts it: no ready pulse and no write; the requester must re-request.

## Structure
- Shared header (alongside the opcode defines) holds:
  - state encodings: IDLE = 2'b00, BUSY_I = 2'b01, BUSY_D = 2'b10
  - grant IDs: GRANT_IF = 0, GRANT_D = 1
  - default `MEM_LATENCY`
- Sub-module `mem_latency_counter`:
  - inputs: `clk`, `reset`, load, load value
  - output: `done` = (count == 0 && busy)
  - the arbiter FSM instantiates one.
- Remaining logic (FSM, grant latch, round-robin, output muxing) stays in `unified_mem_arbiter`.

## Test plan
- **Lone fetch.** Reset, then `if_req`=1, `if_addr`=0x10 at cycle 5; memory word = 0x00500093 → `if_ready` high only at cycle 9, `if_rdata`=0x00500093, `m_we`=0 throughout.
- **Store then load.** `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF → `m_we` high exactly in the `d_ready` cycle. Then a load of 0x100 → `d_rdata`=0xDEADBEEF.
- **Contention.** `if_req` and `d_req` both held high from reset release → grant order IF, D, IF, D. Ready pulses 5 cycles apart (`MEM_LATENCY`=4).
- **Mid-transaction changes.** Change `d_addr` to 0x200 two cycles after grant → `m_addr` stays 0x100. Drop `d_req` one cycle after grant of a store → `d_ready` still pulses and the memory is written.
- **Reset abort.** Assert `reset` one cycle before the done cycle of a store → no `m_we`, no `d_ready`, memory unchanged. All outputs 0 in the next cycle.
- **`MEM_LATENCY`=1.** Rebuild with `MEM_LATENCY`=1 and issue a single fetch → `if_ready` one cycle after request, then IDLE for one cycle.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified memory arbiter:
// FSM states, grant identifiers and default access latency.
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  localparam int DEF_MEM_LATENCY = 4;

endpackage

// File: rtl/mem_latency_counter.sv
// Down-counter timing one memory access; done marks
// the final cycle of a loaded access.
module mem_latency_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;
  logic         busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      busy  <= 1'b1;
    end else if (busy) begin
      if (count == '0)
        busy <= 1'b0;
      else
        count <= count - 1'b1;
    end
  end

  assign done = busy && (count == '0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory
// between instruction fetch and data access.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [WORD_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [WORD_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic [WORD_W-1:0] m_wdata,
  output logic              m_we,
  input  logic [WORD_W-1:0] m_rdata
);

  localparam int CNT_W =
    (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL =
    CNT_W'(MEM_LATENCY - 1);

  state_t state, state_nx;
  logic   last_grant;
  logic   pend_we;
  logic   done;
  logic   grant;
  logic   grant_id;

  mem_latency_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (grant),
    .load_val (LOAD_VAL),
    .done     (done)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_id = GRANT_IF;
    unique case (state)
      IDLE: begin
        if (if_req && d_req) begin
          grant    = 1'b1;
          grant_id = ~last_grant;
        end else if (if_req) begin
          grant    = 1'b1;
          grant_id = GRANT_IF;
        end else if (d_req) begin
          grant    = 1'b1;
          grant_id = GRANT_D;
        end
        if (grant)
          state_nx = (grant_id == GRANT_D) ? BUSY_D : BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (done)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address/data are captured once; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_addr     <= '0;
      m_wdata    <= '0;
      pend_we    <= 1'b0;
      last_grant <= GRANT_D;
    end else if (grant) begin
      last_grant <= grant_id;
      if (grant_id == GRANT_D) begin
        m_addr  <= d_addr;
        pend_we <= d_we;
        if (d_we)
          m_wdata <= d_wdata;
      end else begin
        m_addr  <= if_addr;
        pend_we <= 1'b0;
      end
    end
  end

  assign if_ready = (state == BUSY_I) && done;
  assign d_ready  = (state == BUSY_D) && done;
  assign m_we     = d_ready && pend_we;
  assign if_rdata = if_ready ? m_rdata : '0;
  assign d_rdata  = d_ready ? m_rdata : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed scoreboard bench for unified_mem_arbiter
// (latency 4 instance plus a latency 1 instance).
module tb_unified_mem_arbiter;

  typedef struct {
    bit          side;
    logic [31:0] data;
    bit          we;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];
  exp_t        mon_e;

  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [31:0] m_rdata;

  logic        if1_req = 1'b0;
  logic [31:0] if1_addr = '0;
  logic        if1_ready;
  logic [31:0] if1_rdata;
  logic        d1_req = 1'b0;
  logic        d1_we = 1'b0;
  logic [31:0] d1_addr = '0;
  logic [31:0] d1_wdata = '0;
  logic        d1_ready;
  logic [31:0] d1_rdata;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_we;
  logic [31:0] m1_rdata;

  logic [31:0] mem [0:255];
  logic        pl_clr = 1'b0;
  logic        pl_we = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign m_rdata  = mem[m_addr[9:2]];
  assign m1_rdata = m1_addr ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (m_we) begin
      mem[m_addr[9:2]] <= m_wdata;
    end
    if (pl_we) mem[pl_addr] <= pl_data;
  end

  unified_mem_arbiter #(.MEM_LATENCY(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ready (if_ready),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .d_rdata  (d_rdata),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_we     (m_we),
    .m_rdata  (m_rdata)
  );

  unified_mem_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if1_req),
    .if_addr  (if1_addr),
    .if_ready (if1_ready),
    .if_rdata (if1_rdata),
    .d_req    (d1_req),
    .d_we     (d1_we),
    .d_addr   (d1_addr),
    .d_wdata  (d1_wdata),
    .d_ready  (d1_ready),
    .d_rdata  (d1_rdata),
    .m_addr   (m1_addr),
    .m_wdata  (m1_wdata),
    .m_we     (m1_we),
    .m_rdata  (m1_rdata)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit side, input logic [31:0] data,
                      input bit we, input int c);
    exp_t e;
    e.side = side;
    e.data = data;
    e.we   = we;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input int limit);
    for (int i = 0; i < limit && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("sb_drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (if_ready || d_ready) begin
        chk("both_ready", {63'd0, if_ready & d_ready}, 64'd0);
        if (sb.size() == 0) begin
          chk("unexpected_ready", {62'd0, if_ready, d_ready}, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ready_side", {63'd0, d_ready}, {63'd0, mon_e.side});
          chk("rdata", {32'd0, d_ready ? d_rdata : if_rdata},
              {32'd0, mon_e.data});
          chk("m_we_done", {63'd0, m_we}, {63'd0, mon_e.we});
          if (mon_e.cyc >= 0)
            chk("ready_cycle", 64'(cyc), 64'(mon_e.cyc));
        end
      end else begin
        chk("idle_rdata", {if_rdata, d_rdata}, 64'd0);
        chk("idle_m_we", {63'd0, m_we}, 64'd0);
      end
    end
  end

  initial begin
    int t;
    reset  = 1'b1;
    pl_clr = 1'b1;
    tick();
    pl_clr  = 1'b0;
    pl_we   = 1'b1;
    pl_addr = 8'd4;
    pl_data = 32'h0050_0093;
    tick();
    pl_we = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_m_addr", {32'd0, m_addr}, 64'd0);
    chk("rst_m_wdata", {32'd0, m_wdata}, 64'd0);
    chk("rst_ready", {62'd0, if_ready, d_ready}, 64'd0);
    chk("rst_m_we", {63'd0, m_we}, 64'd0);
    tick();
    reset = 1'b0;

    // lone fetch
    tick();
    if_req  = 1'b1;
    if_addr = 32'h10;
    push(1'b0, 32'h0050_0093, 1'b0, cyc + 4);
    wait_empty(20);
    if_req = 1'b0;

    // store then load
    tick();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hDEAD_BEEF;
    push(1'b1, 32'h0, 1'b1, cyc + 4);
    wait_empty(20);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    chk("store_mem", {32'd0, mem[64]}, {32'd0, 32'hDEAD_BEEF});
    d_req  = 1'b1;
    d_addr = 32'h100;
    push(1'b1, 32'hDEAD_BEEF, 1'b0, cyc + 4);
    wait_empty(20);
    d_req = 1'b0;

    // mid-transaction input changes
    tick();
    t       = cyc;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'hCAFE_F00D;
    push(1'b1, 32'hDEAD_BEEF, 1'b1, t + 4);
    tick();
    tick();
    d_req = 1'b0;
    tick();
    d_addr  = 32'h200;
    d_wdata = 32'h0;
    @(negedge clk);
    chk("hold_m_addr", {32'd0, m_addr}, 64'h100);
    chk("hold_m_wdata", {32'd0, m_wdata}, 64'hCAFE_F00D);
    wait_empty(20);
    d_we = 1'b0;
    tick();
    chk("drop_mem", {32'd0, mem[64]}, 64'hCAFE_F00D);
    chk("drop_other", {32'd0, mem[128]}, 64'h0);

    // reset aborts a store
    t       = cyc;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'h1111_1111;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    chk("abort_cycle", 64'(cyc), 64'(t + 4));
    chk("abort_ready", {62'd0, if_ready, d_ready}, 64'd0);
    chk("abort_m_we", {63'd0, m_we}, 64'd0);
    chk("abort_m_addr", {32'd0, m_addr}, 64'd0);
    chk("abort_m_wdata", {32'd0, m_wdata}, 64'd0);
    repeat (3) tick();
    chk("abort_mem", {32'd0, mem[64]}, 64'hCAFE_F00D);

    // continuous contention from reset release
    reset   = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h10;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h100;
    tick();
    tick();
    reset = 1'b0;
    t     = cyc;
    push(1'b0, 32'h0050_0093, 1'b0, t + 4);
    push(1'b1, 32'hCAFE_F00D, 1'b0, t + 9);
    push(1'b0, 32'h0050_0093, 1'b0, t + 14);
    push(1'b1, 32'hCAFE_F00D, 1'b0, t + 19);
    wait_empty(40);
    if_req = 1'b0;
    d_req  = 1'b0;

    // latency 1 instance
    tick();
    t        = cyc;
    if1_req  = 1'b1;
    if1_addr = 32'h40;
    @(negedge clk);
    chk("l1_not_yet", {63'd0, if1_ready}, 64'd0);
    tick();
    @(negedge clk);
    chk("l1_cycle", 64'(cyc), 64'(t + 1));
    chk("l1_ready", {63'd0, if1_ready}, 64'd1);
    chk("l1_rdata", {32'd0, if1_rdata}, 64'hA5A5_0040);
    chk("l1_m_we", {63'd0, m1_we}, 64'd0);
    if1_req = 1'b0;
    @(negedge clk);
    chk("l1_idle_ready", {63'd0, if1_ready}, 64'd0);
    chk("l1_idle_rdata", {32'd0, if1_rdata}, 64'd0);

    tick();
    chk("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
